// File: rtl/data_sram_responder_if.sv
// Request/response bundle between the core's execute stage (master) and the
// data SRAM responder (slave). The optional data_address_error signal exists
// only when DATA_SRAM_ADDRESS_CHECK_EN is defined.
interface data_sram_responder_if;
  logic        data_enabled;
  logic [3:0]  data_write_enabled;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [31:0] data_read_data;
  logic        data_read_valid;
  logic        sram_ready;
`ifdef DATA_SRAM_ADDRESS_CHECK_EN
  logic        data_address_error;

  modport master (
    output data_enabled, data_write_enabled, data_address, data_write_data,
    input  data_read_data, data_read_valid, sram_ready, data_address_error
  );

  modport slave (
    input  data_enabled, data_write_enabled, data_address, data_write_data,
    output data_read_data, data_read_valid, sram_ready, data_address_error
  );
`else
  modport master (
    output data_enabled, data_write_enabled, data_address, data_write_data,
    input  data_read_data, data_read_valid, sram_ready
  );

  modport slave (
    input  data_enabled, data_write_enabled, data_address, data_write_data,
    output data_read_data, data_read_valid, sram_ready
  );
`endif
endinterface

// File: rtl/data_sram_responder.sv
// Responder end of the core's data SRAM interface: byte-lane writes, reads
// returned after READ_LATENCY edges with a one-cycle valid strobe, and a
// post-reset fill of the whole array with INIT_VALUE before sram_ready rises.
// Optional feature: define DATA_SRAM_ADDRESS_CHECK_EN to add data_address_error,
// flagging accepted requests whose address bits above the array index are set.
module data_sram_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] INIT_VALUE   = 32'h0000_0000
) (
  input logic                  clock,
  input logic                  reset_n,
  data_sram_responder_if.slave bus
);

  localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Stages between the array sample and the output register.
  localparam int unsigned PipeDepth = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e          state_q;
  logic [IdxW-1:0] init_count_q;
  logic            sram_ready_q;

  logic [31:0]     mem [DEPTH];

  logic [IdxW-1:0] index;
  logic            req_accept;
  logic            write_fire;
  logic            read_fire;
  logic            init_we;

  logic [31:0]     out_data_in;
  logic            out_valid_in;
  logic [31:0]     read_data_q;
  logic            read_valid_q;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
  assign index      = bus.data_address[IdxW+1:2];
  assign req_accept = bus.data_enabled && (state_q == StReady);
  assign write_fire = req_accept && (bus.data_write_enabled != 4'b0000);
  assign read_fire  = req_accept && (bus.data_write_enabled == 4'b0000);
  // Hold off the fill while reset is asserted so the array is untouched by reset.
  assign init_we    = (state_q == StInit) && reset_n;

  // Init/ready sequencer: walks every word once, then parks in StReady.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StInit;
      init_count_q <= '0;
      sram_ready_q <= 1'b0;
    end else if (state_q == StInit) begin
      init_count_q <= init_count_q + 1'b1;
      if (init_count_q == IdxW'(DEPTH - 1)) begin
        state_q      <= StReady;
        sram_ready_q <= 1'b1;
      end
    end
  end

  // Array write port: initialisation fill or byte-lane request writes.
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_count_q] <= INIT_VALUE;
    end else if (write_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_write_enabled[i]) begin
          mem[index][8*i +: 8] <= bus.data_write_data[8*i +: 8];
        end
      end
    end
  end

  if (READ_LATENCY > 1) begin : g_read_pipe
    logic [31:0]          pipe_data_q [PipeDepth];
    logic [PipeDepth-1:0] pipe_valid_q;

    // Array is sampled at the request edge; later writes cannot disturb it.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pipe_valid_q <= '0;
        for (int i = 0; i < PipeDepth; i++) begin
          pipe_data_q[i] <= '0;
        end
      end else begin
        pipe_valid_q[0] <= read_fire;
        pipe_data_q[0]  <= mem[index];
        for (int i = 1; i < PipeDepth; i++) begin
          pipe_valid_q[i] <= pipe_valid_q[i-1];
          pipe_data_q[i]  <= pipe_data_q[i-1];
        end
      end
    end

    assign out_data_in  = pipe_data_q[PipeDepth-1];
    assign out_valid_in = pipe_valid_q[PipeDepth-1];
  end else begin : g_read_direct
    assign out_data_in  = mem[index];
    assign out_valid_in = read_fire;
  end

  // Output register: data holds the last result, valid marks a fresh one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= out_valid_in;
      if (out_valid_in) begin
        read_data_q <= out_data_in;
      end
    end
  end

  assign bus.data_read_data  = read_data_q;
  assign bus.data_read_valid = read_valid_q;
  assign bus.sram_ready      = sram_ready_q;

`ifdef DATA_SRAM_ADDRESS_CHECK_EN
  logic addr_hi;
  logic out_err_in;
  logic addr_error_q;

  assign addr_hi = |bus.data_address[31:IdxW+2];

  if (READ_LATENCY > 1) begin : g_err_pipe
    logic [PipeDepth-1:0] err_pipe_q;

    // Read errors travel with their read so the pulse lines up with valid.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        err_pipe_q <= '0;
      end else begin
        err_pipe_q[0] <= read_fire && addr_hi;
        for (int i = 1; i < PipeDepth; i++) begin
          err_pipe_q[i] <= err_pipe_q[i-1];
        end
      end
    end

    assign out_err_in = err_pipe_q[PipeDepth-1];
  end else begin : g_err_direct
    assign out_err_in = read_fire && addr_hi;
  end

  // Write errors flag at the write edge, read errors at the data edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_error_q <= 1'b0;
    end else begin
      addr_error_q <= out_err_in || (write_fire && addr_hi);
    end
  end

  assign bus.data_address_error = addr_error_q;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (READ_LATENCY 1, 2, 3) with
// DEPTH=16 and INIT_VALUE=32'hDEAD_BEEF share one stimulus stream.
module tb_data_sram_responder;

  localparam int unsigned Depth     = 16;
  localparam logic [31:0] InitValue = 32'hDEAD_BEEF;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  data_sram_responder_if if_l1 ();
  data_sram_responder_if if_l2 ();
  data_sram_responder_if if_l3 ();

  data_sram_responder #(.DEPTH(Depth), .READ_LATENCY(1), .INIT_VALUE(InitValue)) dut_l1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_l1)
  );
  data_sram_responder #(.DEPTH(Depth), .READ_LATENCY(2), .INIT_VALUE(InitValue)) dut_l2 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_l2)
  );
  data_sram_responder #(.DEPTH(Depth), .READ_LATENCY(3), .INIT_VALUE(InitValue)) dut_l3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_l3)
  );

  logic [31:0] rd_data [3];
  logic [2:0]  rd_valid;
  logic [2:0]  rdy;

  assign rd_data[0] = if_l1.data_read_data;
  assign rd_data[1] = if_l2.data_read_data;
  assign rd_data[2] = if_l3.data_read_data;
  assign rd_valid   = {if_l3.data_read_valid, if_l2.data_read_valid, if_l1.data_read_valid};
  assign rdy        = {if_l3.sram_ready, if_l2.sram_ready, if_l1.sram_ready};

`ifdef DATA_SRAM_ADDRESS_CHECK_EN
  logic [2:0] addr_err;
  assign addr_err = {if_l3.data_address_error, if_l2.data_address_error,
                     if_l1.data_address_error};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference contents and per-instance expected output delay lines.
  logic [31:0] model [Depth];
  logic        sh_v  [3][4];
  logic        sh_e  [3][4];
  logic [31:0] sh_d  [3][4];
  logic [31:0] hold  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd);
    if_l1.data_enabled = en; if_l1.data_write_enabled = we;
    if_l1.data_address = addr; if_l1.data_write_data = wd;
    if_l2.data_enabled = en; if_l2.data_write_enabled = we;
    if_l2.data_address = addr; if_l2.data_write_data = wd;
    if_l3.data_enabled = en; if_l3.data_write_enabled = we;
    if_l3.data_address = addr; if_l3.data_write_data = wd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < Depth; i++) model[i] = InitValue;
    for (int d = 0; d < 3; d++) begin
      hold[d] = 32'h0;
      for (int j = 0; j < 4; j++) begin
        sh_v[d][j] = 1'b0;
        sh_e[d][j] = 1'b0;
        sh_d[d][j] = 32'h0;
      end
    end
  endtask

  // One request cycle in READY, then compare every instance's outputs.
  task automatic op(input logic en, input logic [3:0] we, input logic [31:0] addr,
                    input logic [31:0] wd);
    logic        is_rd;
    logic        is_wr;
    logic        hi;
    logic [31:0] rv;
    int          idx;
    idx   = int'(addr[5:2]);
    is_rd = en && (we == 4'b0000);
    is_wr = en && (we != 4'b0000);
    hi    = (addr[31:6] != 26'h0);
    rv    = model[idx];
    if (is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    drive(en, we, addr, wd);
    step();
    for (int d = 0; d < 3; d++) begin
      for (int j = d; j > 0; j--) begin
        sh_v[d][j] = sh_v[d][j-1];
        sh_e[d][j] = sh_e[d][j-1];
        sh_d[d][j] = sh_d[d][j-1];
      end
      sh_v[d][0] = is_rd;
      sh_e[d][0] = is_rd && hi;
      sh_d[d][0] = rv;
      if (sh_v[d][d]) hold[d] = sh_d[d][d];
      check($sformatf("valid_L%0d@%h", d + 1, addr), 32'(rd_valid[d]), 32'(sh_v[d][d]));
      check($sformatf("data_L%0d@%h", d + 1, addr), rd_data[d], hold[d]);
`ifdef DATA_SRAM_ADDRESS_CHECK_EN
      check($sformatf("addr_err_L%0d@%h", d + 1, addr), 32'(addr_err[d]),
            32'((is_wr && hi) || sh_e[d][d]));
`endif
    end
  endtask

  // Call just after reset release (mid-cycle); reads are issued and must be dropped.
  task automatic wait_init(input string tag);
    for (int c = 1; c <= Depth; c++) begin
      drive(1'b1, 4'b0000, 32'(c * 4), 32'h0);
      step();
      check($sformatf("%s_ready_edge%0d", tag, c), 32'(rdy), (c == Depth) ? 32'h7 : 32'h0);
      check($sformatf("%s_no_valid_edge%0d", tag, c), 32'(rd_valid), 32'h0);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic read_all_words();
    for (int i = 0; i < Depth; i++) op(1'b1, 4'b0000, 32'(i * 4), 32'h0);
    repeat (3) op(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  initial begin
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    clear_model();
    reset_n = 1'b0;
    #1;
    check("reset_ready", 32'(rdy), 32'h0);
    check("reset_valid", 32'(rd_valid), 32'h0);
    for (int d = 0; d < 3; d++) check($sformatf("reset_data_L%0d", d + 1), rd_data[d], 32'h0);
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    wait_init("init");

    // Every word carries the fill value.
    read_all_words();

    // Byte lanes: only lanes 0 and 2 take the second write.
    op(1'b1, 4'b1111, 32'h40, 32'h1122_3344);
    op(1'b1, 4'b0101, 32'h40, 32'hAAAA_AAAA);
    op(1'b1, 4'b0000, 32'h40, 32'h0);
    repeat (2) op(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int d = 0; d < 3; d++) check($sformatf("lanes_L%0d", d + 1), rd_data[d], 32'h11AA_33AA);

    // Latency: back-to-back reads, strobes in order, data held afterwards.
    op(1'b1, 4'b1111, 32'h0, 32'h1);
    op(1'b1, 4'b1111, 32'h4, 32'h2);
    op(1'b1, 4'b1111, 32'h8, 32'h3);
    op(1'b1, 4'b0000, 32'h0, 32'h0);
    op(1'b1, 4'b0000, 32'h4, 32'h0);
    op(1'b1, 4'b0000, 32'h8, 32'h0);
    repeat (3) op(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("hold_data_L%0d", d + 1), rd_data[d], 32'h3);
      check($sformatf("hold_valid_L%0d", d + 1), 32'(rd_valid[d]), 32'h0);
    end

    // Hazards: read 5, overwrite with 9 next cycle, read again.
    op(1'b1, 4'b1111, 32'h10, 32'h5);
    op(1'b1, 4'b0000, 32'h10, 32'h0);
    op(1'b1, 4'b1111, 32'h10, 32'h9);
    op(1'b1, 4'b0000, 32'h10, 32'h0);
    repeat (3) op(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int d = 0; d < 3; d++) check($sformatf("hazard_L%0d", d + 1), rd_data[d], 32'h9);

    // Wrap: 0x44 aliases word 1.
    op(1'b1, 4'b1111, 32'h44, 32'h7);
    op(1'b1, 4'b0000, 32'h04, 32'h0);
    repeat (3) op(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int d = 0; d < 3; d++) check($sformatf("wrap_L%0d", d + 1), rd_data[d], 32'h7);

    // Reset between a read's request edge and its data edge.
    drive(1'b1, 4'b0000, 32'h10, 32'h0);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(rd_valid), 32'h0);
    check("midreset_ready", 32'(rdy), 32'h0);
    for (int d = 0; d < 3; d++) check($sformatf("midreset_data_L%0d", d + 1), rd_data[d], 32'h0);
    repeat (2) begin
      step();
      check("inreset_valid", 32'(rd_valid), 32'h0);
    end
    #3;
    reset_n = 1'b1;
    // Abort a partial fill; the next one must take the full Depth cycles again.
    repeat (5) step();
    check("partial_ready", 32'(rdy), 32'h0);
    #2;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    clear_model();
    wait_init("reinit");
    read_all_words();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the core's data SRAM interface.
- Accepts the enable / byte-write-enable / word-address / write-data requests issued by the execute stage each cycle.
- Performs byte-lane writes and returns read data after a fixed, parameterised latency, with a valid strobe.
- Contains a post-reset initialisation state machine that fills the array with INIT_VALUE before signalling ready. It sits at the top level between the core and the data memory.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, 2..65536
READ_LATENCY, 1, edges from request sample to data visible; legal 1..4
INIT_VALUE, 32'h0000_0000, word written to every location during initialisation

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
data_enabled  input  1  request strobe
data_write_enabled  input  4  byte-lane write enables; lane i = bits [8i+7:8i]
data_address  input  32  byte address; bits [1:0] ignored
data_write_data  input  32  write data, pre-replicated/shifted by requester
data_read_data  output  32  read data
data_read_valid  output  1  one-cycle strobe, data_read_data holds a new read result
sram_ready  output  1  high once initialisation complete

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM to INIT; init counter = 0; sram_ready = 0; data_read_valid = 0; data_read_data = 0.
  - All latency-pipeline valid bits cleared. Array contents are not reset.
- Index = data_address[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM INIT:
  - Each cycle writes INIT_VALUE to word[counter], then increments counter.
  - At counter == DEPTH-1, writes the last word and moves to READY.
  - INIT lasts exactly DEPTH cycles after reset release. sram_ready rises on the edge that enters READY.
  - All requests during INIT are dropped: no write, no read strobe.
- FSM READY: stays until reset. Requests are served every cycle with no backpressure.
- Write:
  - Condition: data_enabled & |data_write_enabled in READY.
  - At that edge, updates only the lanes whose enable bit is set; other lanes are unchanged.
  - No read strobe is generated.
- Read:
  - Condition: data_enabled & data_write_enabled == 0 in READY.
  - The array is sampled at request edge E.
  - Result and valid move through a READ_LATENCY-deep pipeline. data_read_data and data_read_valid update at edge E+READ_LATENCY-1. For READ_LATENCY=1 they update at E itself (classic synchronous SRAM).
  - One read accepted per cycle. Back-to-back reads produce back-to-back valid strobes in order.
- Read-after-write: a write at edge E is visible to a read sampled at edge E+1 or later.
- Write-after-read: a write at edge E+1 does not alter data of a read sampled at E, even when READ_LATENCY > 1.
- Output hold: data_read_data holds the last read result until the next valid result. data_read_valid is high only in cycles carrying a new result.
- Reset mid-operation:
  - In-flight reads are discarded; no valid strobe is emitted.
  - A partial INIT is restarted from word 0.

Optional Feature:
- Macro DATA_SRAM_ADDRESS_CHECK_EN.
- When defined, adds output data_address_error (1 bit, reset 0). It pulses for one cycle, aligned with where data_read_valid would be for a read (edge E+READ_LATENCY-1) or at edge E for a write, when an accepted request has data_address[31:log2(DEPTH)+2] != 0.
- The access still proceeds with wrapped indexing.
- When undefined, the port and its logic are absent, and out-of-range addresses wrap silently.

Test Plan:
- Init:
  - Stimulus: DEPTH=16, INIT_VALUE=32'hDEAD_BEEF; release reset; drive read requests during INIT.
  - Required: sram_ready rises exactly 16 cycles after release; no data_read_valid during INIT; reads of words 0..15 afterwards all return 32'hDEAD_BEEF.
- Byte lanes:
  - Stimulus: write 32'h1122_3344 enables 4'b1111 at address 0x40; then 32'hAAAA_AAAA enables 4'b0101 at 0x40; then read 0x40.
  - Required: read returns 32'h11AA_33AA.
- Latency:
  - Stimulus: READ_LATENCY=3; reads to 0x0, 0x4, 0x8 on consecutive cycles, holding 1, 2, 3.
  - Required: valid strobes at edges E+2, E+3, E+4 carrying 1, 2, 3; data_read_data holds 3 afterwards with valid low.
- Hazards:
  - Stimulus: READ_LATENCY=2; read 0x10 (holds 5) at E, write 9 to 0x10 at E+1, read 0x10 at E+2.
  - Required: returns 5, then 9.
- Wrap and error check:
  - Stimulus: DEPTH=16, DATA_SRAM_ADDRESS_CHECK_EN defined; write 7 to 0x44; read 0x04.
  - Required: read returns 7; data_address_error pulses once for the write and never for the read.
- Reset mid-stream:
  - Stimulus: READ_LATENCY=2; assert reset_n low between a read request edge and its data edge.
  - Required: data_read_valid stays 0, outputs read 0, INIT restarts from word 0.
